// File: rtl/pe_cam_multi.sv
// Registered priority encoder for CAM match lines: drains every set bit of an
// accepted match vector in priority order, one index per beat, with hit/last/count tags.
module pe_cam_multi #(
  parameter int unsigned W       = 64,
  parameter bit          PRI_MSB = 1'b0,
  localparam int unsigned LOG2W  = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_oht,
  input  logic             in_first,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [LOG2W-1:0] out_bin,
  output logic             out_hit,
  output logic             out_last,
  output logic [LOG2W:0]   out_cnt,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int unsigned CW = LOG2W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     vec_q, vec_d;
  logic             first_q, first_d;
  logic [LOG2W-1:0] bin_q, bin_d;
  logic             hit_q, hit_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             rdy_q, rdy_d;

  // Index of the highest-priority set bit; 0 for an empty vector.
  function automatic logic [LOG2W-1:0] enc(input logic [W-1:0] v);
    logic [LOG2W-1:0] idx;
    idx = '0;
    if (PRI_MSB) begin
      for (int i = 0; i < int'(W); i++) begin
        if (v[i]) idx = LOG2W'(i);
      end
    end else begin
      for (int i = int'(W) - 1; i >= 0; i--) begin
        if (v[i]) idx = LOG2W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(W); i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [LOG2W-1:0] idx_c;
  logic [W-1:0]     vec_clr_c;
  logic             le1_c;

  // Encode the current residue and strip the encoded bit for the next beat.
  always_comb begin
    idx_c            = enc(vec_q);
    vec_clr_c        = vec_q;
    vec_clr_c[idx_c] = 1'b0;
    le1_c            = ((vec_q & (vec_q - W'(1))) == '0);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    first_d = first_q;
    bin_d   = bin_q;
    hit_d   = hit_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_vld) begin
          vec_d   = in_oht;
          first_d = in_first;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bin_d   = idx_c;
        hit_d   = |vec_q;
        cnt_d   = popcnt(vec_q);
        last_d  = le1_c | first_q;
        vec_d   = vec_clr_c;
        vld_d   = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_rdy) begin
          if (last_q) begin
            vec_d   = '0;
            vld_d   = 1'b0;
            state_d = IDLE;
          end else begin
            bin_d  = idx_c;
            vec_d  = vec_clr_c;
            last_d = (vec_q != '0) && le1_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      first_q <= 1'b0;
      bin_q   <= '0;
      hit_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      first_q <= first_d;
      bin_q   <= bin_d;
      hit_q   <= hit_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_bin  = bin_q;
  assign out_hit  = hit_q;
  assign out_last = last_q;
  assign out_cnt  = cnt_q;
  assign out_vld  = vld_q;

endmodule

// File: tb/tb_pe_cam_multi.sv
// Directed bench for pe_cam_multi: LSB- and MSB-priority instances run in lockstep,
// each checked against a queue of beats predicted from the driven vector.
module tb_pe_cam_multi;

  typedef struct packed {
    logic [5:0] bin;
    logic       hit;
    logic       last;
    logic [6:0] cnt;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] in_oht = '0;
  logic        in_first = 1'b0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b1;

  logic        in_rdy0, hit0, last0, vld0;
  logic [5:0]  bin0;
  logic [6:0]  cnt0;
  logic        in_rdy1, hit1, last1, vld1;
  logic [5:0]  bin1;
  logic [6:0]  cnt1;

  int vectors = 0;
  int miscompares = 0;
  beat_t q0[$];
  beat_t q1[$];
  int lat, span;

  always #5 clk = ~clk;

  pe_cam_multi #(.W(64), .PRI_MSB(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_oht(in_oht), .in_first(in_first), .in_vld(in_vld),
    .in_rdy(in_rdy0), .out_bin(bin0), .out_hit(hit0), .out_last(last0), .out_cnt(cnt0),
    .out_vld(vld0), .out_rdy(out_rdy)
  );

  pe_cam_multi #(.W(64), .PRI_MSB(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_oht(in_oht), .in_first(in_first), .in_vld(in_vld),
    .in_rdy(in_rdy1), .out_bin(bin1), .out_hit(hit1), .out_last(last1), .out_cnt(cnt1),
    .out_vld(vld1), .out_rdy(out_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference beat list: ascending index order for LSB priority, descending for MSB.
  task automatic push_exp(input logic [63:0] v, input logic f);
    int n = 0;
    int k;
    beat_t b;
    for (int i = 0; i < 64; i++) if (v[i]) n++;
    if (n == 0) begin
      b = '0;
      b.last = 1'b1;
      q0.push_back(b);
      q1.push_back(b);
      return;
    end
    k = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i] && !(f && k > 0)) begin
        k++;
        b.bin = 6'(i); b.hit = 1'b1; b.cnt = 7'(n); b.last = f || (k == n);
        q0.push_back(b);
      end
    end
    k = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i] && !(f && k > 0)) begin
        k++;
        b.bin = 6'(i); b.hit = 1'b1; b.cnt = 7'(n); b.last = f || (k == n);
        q1.push_back(b);
      end
    end
  endtask

  task automatic send(input logic [63:0] v, input logic f);
    int t = 0;
    @(negedge clk);
    while (!in_rdy0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_rdy_before_send", {31'd0, in_rdy0}, 32'd1);
    in_oht   = v;
    in_first = f;
    in_vld   = 1'b1;
    push_exp(v, f);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_oht = {$urandom, $urandom};
  endtask

  task automatic drain(input int max_beats, input bit rnd, input bit pulse,
                       output int first_lat, output int beat_span);
    int it = 0;
    int beats = 0;
    int first_it = -1;
    int last_it = 0;
    beat_t o0, o1;
    while (q0.size() > 0 && beats < max_beats && it < 400) begin
      @(negedge clk);
      it++;
      out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_vld  = pulse && (it == 3);
      if (pulse && it == 3) in_oht = {$urandom, $urandom};
      if (vld0) begin
        if (first_it < 0) first_it = it;
        o0 = {bin0, hit0, last0, cnt0};
        o1 = {bin1, hit1, last1, cnt1};
        chk("in_rdy_low_during_drain", {31'd0, in_rdy0}, 32'd0);
        chk("beat_lsb", 32'(o0), 32'(q0[0]));
        chk("beat_msb", 32'(o1), 32'(q1[0]));
        if (out_rdy) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
          beats++;
          last_it = it;
        end
      end
    end
    chk("drain_within_budget", {31'd0, (it < 400)}, 32'd1);
    if (it >= 400) begin
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    first_lat = first_it;
    beat_span = last_it - first_it + 1;
  endtask

  // After the final handshake the block must be idle and stay silent.
  task automatic post(input string tag);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk({tag, "_in_rdy"}, {31'd0, in_rdy0}, 32'd1);
      chk({tag, "_idle"}, {30'd0, vld0, vld1}, 32'd0);
    end
    chk({tag, "_queue_empty"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_oht  = {$urandom, $urandom};
      in_vld  = 1'($urandom_range(0, 1));
      in_first = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outs_lsb", {17'd0, bin0, hit0, last0, cnt0, vld0}, 32'd0);
      chk("reset_outs_msb", {17'd0, bin1, hit1, last1, cnt1, vld1}, 32'd0);
      chk("reset_in_rdy", {30'd0, in_rdy0, in_rdy1}, 32'd3);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    rst_n   = 1'b1;

    send(64'h0, 1'b0);
    drain(100, 1'b0, 1'b0, lat, span);
    chk("zero_latency", 32'(lat), 32'd2);
    post("zero");

    send(64'h8000_0000_0001_0012, 1'b0);
    drain(100, 1'b0, 1'b0, lat, span);
    chk("multi_back_to_back", 32'(span), 32'd4);
    post("multi");

    send(64'h8000_0000_0001_0012, 1'b1);
    drain(100, 1'b0, 1'b0, lat, span);
    post("first_only");

    send(64'h5, 1'b0);
    drain(100, 1'b1, 1'b1, lat, span);
    post("backpressure");

    send({64{1'b1}}, 1'b0);
    drain(100, 1'b0, 1'b0, lat, span);
    chk("all_ones_span", 32'(span), 32'd64);
    send(64'h2, 1'b0);
    drain(100, 1'b0, 1'b0, lat, span);
    post("after_all_ones");

    send(64'hF0, 1'b0);
    drain(2, 1'b0, 1'b0, lat, span);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_vld", {30'd0, vld0, vld1}, 32'd0);
    chk("mid_reset_outs", {18'd0, bin0, hit0, last0, cnt0}, 32'd0);
    chk("mid_reset_in_rdy", {31'd0, in_rdy0}, 32'd1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h8, 1'b0);
    drain(100, 1'b0, 1'b0, lat, span);
    post("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
